// File: rtl/wb_wait_pkg.sv
// Shared types, LFSR constants and helpers for the wait-state Wishbone memory.
package wb_wait_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_wait_state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 counted from the output end (bits 0,2,3,5).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int unsigned byte_lanes(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/wb_wait_mem_be_ram.sv
// Single-port byte-enabled RAM with a registered read port (block-RAM style).
module be_ram
  import wb_wait_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DEPTH_LOG2-1:0]   addr_i,
  input  logic [DWIDTH/8-1:0]     be_i,
  input  logic [DWIDTH-1:0]       wdata_i,
  output logic [DWIDTH-1:0]       rdata_o
);

  localparam int unsigned LANES = byte_lanes(DWIDTH);
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  logic [DWIDTH-1:0] mem_q [0:WORDS-1];

  // Per-lane write and registered read of the same address.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(LANES); b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/wb_wait_mem.sv
// Wishbone-style slave memory with programmable latency, jitter, decode and abort.
module wb_wait_mem
  import wb_wait_pkg::*;
#(
  parameter int unsigned     AWIDTH      = 32,
  parameter int unsigned     DWIDTH      = 32,
  parameter int unsigned     DEPTH_LOG2  = 15,
  parameter int unsigned     LATENCY     = 3,
  parameter int unsigned     JITTER_BITS = 0,
  parameter logic [AWIDTH-1:0] BASE      = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [AWIDTH-1:0]   adr_i,
  input  logic [DWIDTH/8-1:0] sel_i,
  input  logic [DWIDTH-1:0]   dat_i,
  output logic [DWIDTH-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                stall_o,
  output logic [31:0]         txn_count
);

  localparam int unsigned LANES  = byte_lanes(DWIDTH);
  localparam int unsigned OFF    = $clog2(LANES);
  localparam int unsigned MEM_AW = DEPTH_LOG2 + OFF;
  localparam int unsigned CNT_W  = $clog2(LATENCY + (1 << JITTER_BITS)) + 1;

  wb_wait_state_t        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [15:0]           lfsr_q;
  logic [DEPTH_LOG2-1:0] adr_q;
  logic                  we_q;
  logic [LANES-1:0]      sel_q;
  logic [DWIDTH-1:0]     dat_q;
  logic                  hit_q;

  logic [DEPTH_LOG2-1:0] idx_c;
  logic [DEPTH_LOG2-1:0] ram_addr_c;
  logic                  ram_we_c;
  logic [DWIDTH-1:0]     ram_rdata;
  logic                  hit_c;
  logic [CNT_W-1:0]      jitter_c;

  assign idx_c = adr_i[MEM_AW-1:OFF];

  // Range decode: everything above the memory window must match BASE.
  if (MEM_AW < AWIDTH) begin : g_dec
    assign hit_c = (adr_i[AWIDTH-1:MEM_AW] == BASE[AWIDTH-1:MEM_AW]);
  end else begin : g_nodec
    assign hit_c = 1'b1;
  end

  // Byte-offset bits only select lanes, which sel_i already covers.
  if (OFF > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^adr_i[OFF-1:0];
  end

  // Extra wait states taken from the LFSR at accept time.
  if (JITTER_BITS > 0) begin : g_jit
    assign jitter_c = CNT_W'(lfsr_q[JITTER_BITS-1:0]);
  end else begin : g_nojit
    assign jitter_c = '0;
  end

  // The RAM follows the bus while idle, then holds on the accepted word.
  assign ram_addr_c = (state_q == IDLE) ? idx_c : adr_q;
  assign ram_we_c   = (state_q == RESP) && we_q && hit_q && !rst_i;

  be_ram #(
    .DWIDTH     (DWIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .be_i    (sel_q),
    .wdata_i (dat_q),
    .rdata_o (ram_rdata)
  );

  // Transaction FSM; WAIT always lasts cnt+1 cycles so the response lands L cycles after accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      hit_q     <= 1'b0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      stall_o   <= 1'b0;
      dat_o     <= '0;
      txn_count <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      dat_o  <= '0;
      case (state_q)
        IDLE: begin
          if (cyc_i && stb_i) begin
            adr_q   <= idx_c;
            we_q    <= we_i;
            sel_q   <= sel_i;
            dat_q   <= dat_i;
            hit_q   <= hit_c;
            cnt_q   <= CNT_W'(LATENCY - 1) + jitter_c;
            stall_o <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            stall_o <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            ack_o   <= hit_q;
            err_o   <= !hit_q;
            if (hit_q && !we_q) begin
              dat_o <= ram_rdata;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          txn_count <= txn_count + 32'd1;
          stall_o   <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          stall_o <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_wait_mem.sv
// Directed bench: fixed-latency instance for data/decode/abort/reset, jittered instance for wait states.
module tb_wb_wait_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Fixed-latency instance
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] a_dat, a_count;
  logic        a_ack, a_err, a_stall;

  wb_wait_mem #(.LATENCY(3), .JITTER_BITS(0), .DEPTH_LOG2(15)) u_dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_i(dat), .dat_o(a_dat), .ack_o(a_ack),
    .err_o(a_err), .stall_o(a_stall), .txn_count(a_count)
  );

  // Jittered instance
  logic        j_cyc = 1'b0, j_stb = 1'b0;
  logic [31:0] unused_j_dat, j_count;
  logic        j_ack, j_err, j_stall;

  wb_wait_mem #(.LATENCY(3), .JITTER_BITS(2), .DEPTH_LOG2(8)) u_dut_j (
    .clk_i(clk), .rst_i(rst), .cyc_i(j_cyc), .stb_i(j_stb), .we_i(1'b0),
    .adr_i(32'h0), .sel_i(4'hF), .dat_i(32'h0), .dat_o(unused_j_dat), .ack_o(j_ack),
    .err_o(j_err), .stall_o(j_stall), .txn_count(j_count)
  );

  // Reference LFSR: seed ACE1, shift right, feedback from taps 16,14,13,11.
  logic [15:0] m;
  always @(posedge clk) begin
    if (rst) m <= 16'hACE1;
    else     m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One request on the fixed instance; expects the response exactly 3 cycles after accept.
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_dat);
    int n;
    int st_bad;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(posedge clk);
    n = 0;
    st_bad = 0;
    do begin
      @(negedge clk);
      n++;
      stb = 1'b0;
      if (!a_stall) st_bad++;
    end while (!(a_ack || a_err) && n < 20);
    check({tag, " lat"}, 32'(n - 1), 32'd3);
    check({tag, " ack"}, {31'd0, a_ack}, {31'd0, exp_ack});
    check({tag, " err"}, {31'd0, a_err}, {31'd0, !exp_ack});
    if (!w || !exp_ack) check({tag, " dat"}, a_dat, exp_dat);
    check({tag, " stall"}, 32'(st_bad), 32'd0);
    @(negedge clk);
    cyc = 1'b0;
    check({tag, " pulse"}, {30'd0, a_ack, a_err}, 32'd0);
  endtask

  initial begin
    int bad;
    int done;
    int cycles;
    int n;
    int exp_lat;
    logic busy;
    logic [3:0] seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ack", {31'd0, a_ack}, 32'd0);
    check("rst err", {31'd0, a_err}, 32'd0);
    check("rst stall", {31'd0, a_stall}, 32'd0);
    check("rst dat", a_dat, 32'd0);
    check("rst count", a_count, 32'd0);
    rst = 1'b0;

    // Write then read back
    txn("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0);
    check("wr10 count", a_count, 32'd1);
    txn("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF);
    check("rd10 count", a_count, 32'd2);

    // Byte lanes
    txn("wr20a", 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
    txn("wr20b", 1'b1, 32'h20, 4'h5, 32'h11223344, 1'b1, 32'h0);
    txn("rd20", 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 32'hFF22FF44);
    check("lanes count", a_count, 32'd5);

    // Out of range aliases word 0, which must stay untouched
    txn("wr0", 1'b1, 32'h0, 4'hF, 32'hA5A55A5A, 1'b1, 32'h0);
    txn("wroor", 1'b1, 32'h0002_0000, 4'hF, 32'h0BAD0BAD, 1'b0, 32'h0);
    check("wroor count", a_count, 32'd7);
    txn("rdoor", 1'b0, 32'h0002_0000, 4'hF, 32'h0, 1'b0, 32'h0);
    txn("rd0", 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'hA5A55A5A);
    check("oor count", a_count, 32'd9);

    // Abort one cycle after accept
    txn("wr30", 1'b1, 32'h30, 4'hF, 32'h30303030, 1'b1, 32'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF; dat = 32'hBADBAD00;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort stall", {31'd0, a_stall}, 32'd0);
    bad = 0;
    repeat (6) begin
      if (a_ack || a_err) bad++;
      @(negedge clk);
    end
    check("abort resp", 32'(bad), 32'd0);
    check("abort count", a_count, 32'd10);
    txn("rd30", 1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 32'h30303030);
    check("rd30 count", a_count, 32'd11);

    // Reset during WAIT of a write
    txn("wr40", 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; dat = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst ack", {31'd0, a_ack}, 32'd0);
    check("mrst err", {31'd0, a_err}, 32'd0);
    check("mrst stall", {31'd0, a_stall}, 32'd0);
    check("mrst dat", a_dat, 32'd0);
    check("mrst count", a_count, 32'd0);
    rst = 1'b0;
    cyc = 1'b0;
    txn("rd40", 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'hCAFEF00D);
    check("rd40 count", a_count, 32'd1);

    // Jitter: back-to-back reads, latency = 3 + lfsr[1:0] at accept
    bad = 0; done = 0; cycles = 0; n = 0; exp_lat = 0; busy = 1'b0; seen = '0;
    while (done < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!busy) begin
        if (!j_stall) begin
          j_cyc = 1'b1; j_stb = 1'b1;
          busy = 1'b1; n = 0;
          exp_lat = 3 + int'(m[1:0]);
        end
      end else begin
        n++;
        if (!j_stall || j_err) bad++;
        if (j_ack || j_err) begin
          check("jit lat", 32'(n - 1), 32'(exp_lat));
          if (n - 1 >= 3 && n - 1 <= 6) seen[n - 4] = 1'b1;
          done++;
          busy = 1'b0;
        end else if (n > 20) begin
          check("jit timeout", 32'(n), 32'd0);
          busy = 1'b0;
          cycles = 20000;
        end
      end
    end
    j_cyc = 1'b0; j_stb = 1'b0;
    @(negedge clk);
    check("jit done", 32'(done), 32'd1000);
    check("jit seen", {28'd0, seen}, 32'hF);
    check("jit stall", 32'(bad), 32'd0);
    check("jit count", j_count, 32'd1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
